// File: rtl/defines_pkg.sv
// Shared defaults and arithmetic helpers for the vector MAC datapath.
// Contents:
//   IN_W, ACC_W, NUM_S, VEC_MAX : default parameter values for mac_vec_acc
//   sat_add                     : signed add at a run-time width, returns sum + overflow
//   relu                        : clamps a negative value to zero when enabled
// The helpers work on CALC_W-bit sign-extended values so that any block with
// a width below CALC_W can reuse them and keep the low bits of the result.
package defines_pkg;

  localparam int unsigned IN_W    = 8;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned NUM_S   = 1;
  localparam int unsigned VEC_MAX = 8;

  localparam int unsigned CALC_W = 64;
  localparam logic signed [CALC_W-1:0] MAX_POS = {1'b0, {(CALC_W-1){1'b1}}};

  typedef struct packed {
    logic signed [CALC_W-1:0] sum;
    logic                     ovf;
  } add_res_t;

  // op_a/op_b must be sign-extended w-bit values (1 <= w < CALC_W). The
  // operands are shifted so bit w-1 lands on the MSB; the sign test then
  // needs no variable bit select.
  function automatic add_res_t sat_add(input logic signed [CALC_W-1:0] op_a,
                                       input logic signed [CALC_W-1:0] op_b,
                                       input int unsigned              w,
                                       input logic                     sat);
    add_res_t                 r;
    logic signed [CALC_W-1:0] raw;
    logic signed [CALC_W-1:0] a_top;
    logic signed [CALC_W-1:0] b_top;
    logic signed [CALC_W-1:0] s_top;
    logic signed [CALC_W-1:0] hi;
    int unsigned              sh;
    sh    = CALC_W - w;
    raw   = op_a + op_b;
    a_top = op_a <<< sh;
    b_top = op_b <<< sh;
    s_top = raw <<< sh;
    r.ovf = (a_top[CALC_W-1] == b_top[CALC_W-1]) && (s_top[CALC_W-1] != a_top[CALC_W-1]);
    hi    = MAX_POS >>> sh;
    if (r.ovf && sat) begin
      r.sum = a_top[CALC_W-1] ? ~hi : hi;
    end else begin
      r.sum = s_top >>> sh;
    end
    return r;
  endfunction

  function automatic logic signed [CALC_W-1:0] relu(input logic signed [CALC_W-1:0] v,
                                                     input logic                     en);
    return (en && v[CALC_W-1]) ? '0 : v;
  endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Signed IN_W x IN_W multiplier with NUM_S-1 register stages after the
// multiply (purely combinational when NUM_S == 1).
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   a, b       : signed operands
//   p          : signed 2*IN_W product, delayed NUM_S-1 cycles
module mac_mult_pipe #(
  parameter int unsigned IN_W  = defines_pkg::IN_W,
  parameter int unsigned NUM_S = defines_pkg::NUM_S
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [IN_W-1:0]    a,
  input  logic signed [IN_W-1:0]    b,
  output logic signed [2*IN_W-1:0]  p
);

  logic signed [2*IN_W-1:0] prod;

  assign prod = (2*IN_W)'(a) * (2*IN_W)'(b);

  if (NUM_S == 1) begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign p = prod;
  end else begin : g_pipe
    logic signed [2*IN_W-1:0] st [NUM_S-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int unsigned i = 0; i < NUM_S - 1; i++) st[i] <= '0;
      end else begin
        st[0] <= prod;
        for (int unsigned i = 1; i < NUM_S - 1; i++) st[i] <= st[i-1];
      end
    end

    assign p = st[NUM_S-2];
  end

endmodule

// File: rtl/mac_vec_acc.sv
// Vector dot-product MAC: streams signed a/b pairs, adds unsigned bias x to
// the first product, accumulates over a per-vector length with optional
// saturation, optional ReLU on the result and a per-vector overflow flag.
// Ports:
//   clk, reset          : clock and asynchronous active-high reset
//   valid_in            : element strobe, one element per cycle, no backpressure
//   a, b                : signed operands
//   x                   : unsigned bias, used on the first element only
//   vec_len             : vector length (0 -> 1, > VEC_MAX -> VEC_MAX)
//   sat_en, relu_en     : mode bits, sampled on the first element
//   f                   : signed result, held between valid_out pulses
//   valid_out           : one-cycle pulse per finished vector
//   overflow            : any addition in that vector overflowed
// Pipeline: input regs -> multiplier (NUM_S-1 regs) -> product reg ->
// accumulator -> output regs, so valid_out follows the last element's
// sampling edge by NUM_S+2 edges.
module mac_vec_acc import defines_pkg::*; #(
  parameter int unsigned IN_W    = defines_pkg::IN_W,
  parameter int unsigned ACC_W   = defines_pkg::ACC_W,
  parameter int unsigned NUM_S   = defines_pkg::NUM_S,
  parameter int unsigned VEC_MAX = defines_pkg::VEC_MAX,
  localparam int unsigned LEN_W  = $clog2(VEC_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic signed [IN_W-1:0]   a,
  input  logic signed [IN_W-1:0]   b,
  input  logic        [IN_W-1:0]   x,
  input  logic        [LEN_W-1:0]  vec_len,
  input  logic                     sat_en,
  input  logic                     relu_en,
  output logic signed [ACC_W-1:0]  f,
  output logic                     valid_out,
  output logic                     overflow
);

  typedef struct packed {
    logic            valid;
    logic            first;
    logic            last;
    logic            sat;
    logic            relu;
    logic [IN_W-1:0] x;
  } tag_t;

  logic [LEN_W-1:0]          cnt, len_q, len_eff, len_cur;
  logic                      sat_q, relu_q, first_in, last_in;
  logic signed [IN_W-1:0]    a_r, b_r;
  tag_t                      tag_nxt, in_tag, pt;
  tag_t                      tp [NUM_S];
  logic signed [2*IN_W-1:0]  prod, prod_r;
  logic signed [ACC_W-1:0]   acc;
  logic                      acc_ovf, acc_valid, acc_last, acc_relu;
  add_res_t                  add_res;
  logic signed [CALC_W-1:0]  f_nxt;
  logic                      unused_hi;

  // Input stage: element counter and per-vector mode latch. On the first
  // element the live inputs are used directly since the latch is not yet loaded.
  always_comb begin
    len_eff = vec_len;
    if (vec_len == '0) begin
      len_eff = LEN_W'(1);
    end else if (vec_len > LEN_W'(VEC_MAX)) begin
      len_eff = LEN_W'(VEC_MAX);
    end
    first_in      = (cnt == '0);
    len_cur       = first_in ? len_eff : len_q;
    last_in       = (cnt == len_cur - LEN_W'(1));
    tag_nxt.valid = 1'b1;
    tag_nxt.first = first_in;
    tag_nxt.last  = last_in;
    tag_nxt.sat   = first_in ? sat_en : sat_q;
    tag_nxt.relu  = first_in ? relu_en : relu_q;
    tag_nxt.x     = x;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      len_q  <= '0;
      sat_q  <= 1'b0;
      relu_q <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      in_tag <= '0;
    end else begin
      in_tag <= valid_in ? tag_nxt : '0;
      if (valid_in) begin
        a_r <= a;
        b_r <= b;
        cnt <= last_in ? '0 : cnt + LEN_W'(1);
        if (first_in) begin
          len_q  <= len_eff;
          sat_q  <= sat_en;
          relu_q <= relu_en;
        end
      end
    end
  end

  mac_mult_pipe #(
    .IN_W  (IN_W),
    .NUM_S (NUM_S)
  ) u_mult (
    .clk   (clk),
    .reset (reset),
    .a     (a_r),
    .b     (b_r),
    .p     (prod)
  );

  // Tags ride alongside the multiplier so the last entry lines up with prod_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_S; i++) tp[i] <= '0;
      prod_r <= '0;
    end else begin
      tp[0] <= in_tag;
      for (int unsigned i = 1; i < NUM_S; i++) tp[i] <= tp[i-1];
      prod_r <= prod;
    end
  end

  assign pt = tp[NUM_S-1];

  always_comb begin
    add_res = sat_add(CALC_W'(prod_r), pt.first ? CALC_W'(pt.x) : CALC_W'(acc), ACC_W, pt.sat);
    f_nxt   = relu(CALC_W'(acc), acc_relu);
  end

  // Results are sign-extended to CALC_W; only the low ACC_W bits are kept.
  assign unused_hi = ^{add_res.sum[CALC_W-1:ACC_W], f_nxt[CALC_W-1:ACC_W]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      acc_ovf   <= 1'b0;
      acc_valid <= 1'b0;
      acc_last  <= 1'b0;
      acc_relu  <= 1'b0;
      f         <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      acc_valid <= pt.valid;
      acc_last  <= pt.last;
      acc_relu  <= pt.relu;
      if (pt.valid) begin
        acc     <= add_res.sum[ACC_W-1:0];
        acc_ovf <= pt.first ? add_res.ovf : (acc_ovf | add_res.ovf);
      end
      valid_out <= acc_valid && acc_last;
      if (acc_valid && acc_last) begin
        f        <= f_nxt[ACC_W-1:0];
        overflow <= acc_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mac_vec_acc.sv
// Bench for mac_vec_acc: six instances (NUM_S = 1..6) share one stimulus
// stream; a behavioural model pushes expected results (value, overflow flag,
// due cycle) into one queue per instance.
module tb_mac_vec_acc;

  localparam int NDUT    = 6;
  localparam int VEC_MAX = 8;

  typedef struct packed {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] x;
    logic [3:0] len;
    logic       sat;
    logic       relu;
  } stim_t;

  typedef struct packed {
    logic signed [15:0] f;
    logic               ovf;
    logic [31:0]        cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               valid_in;
  logic signed [7:0]  a, b;
  logic        [7:0]  x;
  logic        [3:0]  vec_len;
  logic               sat_en, relu_en;
  logic signed [15:0] f_o [NDUT];
  logic               vo  [NDUT];
  logic               ov  [NDUT];

  int unsigned cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;

  exp_t  sb [NDUT][$];
  stim_t stim [$];

  int m_cnt = 0, m_len = 1, m_acc = 0;
  bit m_sat, m_relu, m_ovf;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    mac_vec_acc #(
      .IN_W    (8),
      .ACC_W   (16),
      .NUM_S   (k + 1),
      .VEC_MAX (VEC_MAX)
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .a         (a),
      .b         (b),
      .x         (x),
      .vec_len   (vec_len),
      .sat_en    (sat_en),
      .relu_en   (relu_en),
      .f         (f_o[k]),
      .valid_out (vo[k]),
      .overflow  (ov[k])
    );
  end

  function automatic stim_t mk(bit v, int ia, int ib, int ix, int len, bit sat, bit relu);
    stim_t s;
    s.v = v; s.a = 8'(ia); s.b = 8'(ib); s.x = 8'(ix);
    s.len = 4'(len); s.sat = sat; s.relu = relu;
    return s;
  endfunction

  // Reference: 32-bit integer arithmetic with explicit range test for 16 bits.
  task automatic model_elem(input stim_t s, input int unsigned stamp);
    int   pa, pb, base, sum, ln;
    bit   o, first;
    exp_t e;
    first = (m_cnt == 0);
    if (first) begin
      ln     = int'(s.len);
      m_len  = (ln == 0) ? 1 : ((ln > VEC_MAX) ? VEC_MAX : ln);
      m_sat  = s.sat;
      m_relu = s.relu;
    end
    pa   = $signed(s.a);
    pb   = $signed(s.b);
    base = first ? int'(s.x) : m_acc;
    sum  = pa * pb + base;
    o    = (sum > 32767) || (sum < -32768);
    if (o) sum = m_sat ? ((sum > 0) ? 32767 : -32768) : (((sum + 32768) & 65535) - 32768);
    m_ovf = first ? o : (m_ovf | o);
    m_acc = sum;
    m_cnt++;
    if (m_cnt == m_len) begin
      m_cnt = 0;
      e.f   = 16'((m_relu && sum < 0) ? 0 : sum);
      e.ovf = m_ovf;
      e.cyc = stamp;
      for (int k = 0; k < NDUT; k++) sb[k].push_back(e);
    end
  endtask

  task automatic drive(input stim_t s);
    valid_in = s.v;
    a        = s.a;
    b        = s.b;
    x        = s.x;
    vec_len  = s.len;
    sat_en   = s.sat;
    relu_en  = s.relu;
    if (s.v) model_elem(s, cyc + 1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      n_total++;
      if (f_o[k] !== 16'sd0 || vo[k] !== 1'b0 || ov[k] !== 1'b0)
        $display("FAIL reset_state dut%0d got f=%0d vo=%b ovf=%b want f=0 vo=0 ovf=0", k, f_o[k], vo[k], ov[k]);
      else n_pass++;
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t e;
    int   total;
    for (int i = 0; i < 4; i++) stim.push_back(mk(1, i + 1, i + 5, 10, 4, 0, 0));
    total = stim.size() + 16;
    for (int n = 0; n < total; n++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) if (vo[k] === 1'b1) begin
        n_total++;
        if (sb[k].size() == 0) $display("FAIL basic_unexpected dut%0d got f=%0d want no valid_out", k, f_o[k]);
        else begin
          e = sb[k].pop_front();
          if (f_o[k] !== e.f || ov[k] !== e.ovf || cyc !== e.cyc + k + 3)
            $display("FAIL basic_result dut%0d got f=%0d ovf=%b cyc=%0d want f=%0d ovf=%b cyc=%0d", k, f_o[k], ov[k], cyc, e.f, e.ovf, e.cyc + k + 3);
          else n_pass++;
        end
      end
      drive(stim.size() != 0 ? stim.pop_front() : mk(0, 0, 0, 0, 0, 0, 0));
    end
    for (int k = 0; k < NDUT; k++) begin
      n_total++;
      if (sb[k].size() != 0) $display("FAIL basic_missing dut%0d got %0d pending want 0", k, sb[k].size());
      else n_pass++;
      n_total++;
      if (f_o[k] !== 16'sd80 || ov[k] !== 1'b0 || vo[k] !== 1'b0)
        $display("FAIL basic_hold dut%0d got f=%0d ovf=%b vo=%b want f=80 ovf=0 vo=0", k, f_o[k], ov[k], vo[k]);
      else n_pass++;
    end
  endtask

  task automatic test_modes();
    exp_t e;
    int   total;
    stim.push_back(mk(1, -128, -128, 0, 2, 1, 0));
    stim.push_back(mk(1, -128, -128, 0, 2, 0, 0));
    stim.push_back(mk(1, -128, -128, 0, 2, 0, 0));
    stim.push_back(mk(1, -128, -128, 0, 2, 1, 0));
    stim.push_back(mk(1, -1, 5, 0, 1, 0, 1));
    stim.push_back(mk(1, -1, 5, 0, 1, 0, 0));
    total = stim.size() + 16;
    for (int n = 0; n < total; n++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) if (vo[k] === 1'b1) begin
        n_total++;
        if (sb[k].size() == 0) $display("FAIL modes_unexpected dut%0d got f=%0d want no valid_out", k, f_o[k]);
        else begin
          e = sb[k].pop_front();
          if (f_o[k] !== e.f || ov[k] !== e.ovf || cyc !== e.cyc + k + 3)
            $display("FAIL modes_result dut%0d got f=%0d ovf=%b cyc=%0d want f=%0d ovf=%b cyc=%0d", k, f_o[k], ov[k], cyc, e.f, e.ovf, e.cyc + k + 3);
          else n_pass++;
        end
      end
      drive(stim.size() != 0 ? stim.pop_front() : mk(0, 0, 0, 0, 0, 0, 0));
    end
    for (int k = 0; k < NDUT; k++) begin
      n_total++;
      if (sb[k].size() != 0) $display("FAIL modes_missing dut%0d got %0d pending want 0", k, sb[k].size());
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   total, ln, eff;
    for (int i = 0; i < 3; i++) stim.push_back(mk(1, 3 * i - 4, 7 - i, 2, 3, 0, 0));
    for (int i = 0; i < 2; i++) stim.push_back(mk(1, 50 + i, -60, 9, 2, 1, 0));
    stim.push_back(mk(1, 9, -3, 4, 0, 0, 0));
    stim.push_back(mk(1, -7, -7, 1, 0, 0, 1));
    for (int i = 0; i < VEC_MAX; i++) stim.push_back(mk(1, 100, 90 - i, 5, VEC_MAX + 3, 0, 0));
    for (int n = 0; n < 16; n++) begin
      ln  = int'($urandom_range(0, VEC_MAX + 3));
      eff = (ln == 0) ? 1 : ((ln > VEC_MAX) ? VEC_MAX : ln);
      for (int i = 0; i < eff; i++) begin
        if ($urandom_range(0, 2) == 0)
          stim.push_back(mk(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 0, 0, 0));
        stim.push_back(mk(1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                          int'($urandom_range(0, 255)), (i == 0) ? ln : int'($urandom_range(0, 11)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
      end
    end
    total = stim.size() + 16;
    for (int n = 0; n < total; n++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) if (vo[k] === 1'b1) begin
        n_total++;
        if (sb[k].size() == 0) $display("FAIL b2b_unexpected dut%0d got f=%0d want no valid_out", k, f_o[k]);
        else begin
          e = sb[k].pop_front();
          if (f_o[k] !== e.f || ov[k] !== e.ovf || cyc !== e.cyc + k + 3)
            $display("FAIL b2b_result dut%0d got f=%0d ovf=%b cyc=%0d want f=%0d ovf=%b cyc=%0d", k, f_o[k], ov[k], cyc, e.f, e.ovf, e.cyc + k + 3);
          else n_pass++;
        end
      end
      drive(stim.size() != 0 ? stim.pop_front() : mk(0, 0, 0, 0, 0, 0, 0));
    end
    for (int k = 0; k < NDUT; k++) begin
      n_total++;
      if (sb[k].size() != 0) $display("FAIL b2b_missing dut%0d got %0d pending want 0", k, sb[k].size());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   total;
    @(negedge clk);
    drive(mk(1, 1, 1, 0, 4, 0, 0));
    @(negedge clk);
    drive(mk(1, 1, 1, 0, 4, 0, 0));
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    m_cnt = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      n_total++;
      if (f_o[k] !== 16'sd0 || vo[k] !== 1'b0 || ov[k] !== 1'b0)
        $display("FAIL rst_mid_clear dut%0d got f=%0d vo=%b ovf=%b want f=0 vo=0 ovf=0", k, f_o[k], vo[k], ov[k]);
      else n_pass++;
    end
    reset = 1'b0;
    stim.push_back(mk(1, 2, 3, 1, 1, 0, 0));
    total = stim.size() + 16;
    for (int n = 0; n < total; n++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) if (vo[k] === 1'b1) begin
        n_total++;
        if (sb[k].size() == 0) $display("FAIL rst_mid_unexpected dut%0d got f=%0d want no valid_out", k, f_o[k]);
        else begin
          e = sb[k].pop_front();
          if (f_o[k] !== e.f || ov[k] !== e.ovf || cyc !== e.cyc + k + 3)
            $display("FAIL rst_mid_result dut%0d got f=%0d ovf=%b cyc=%0d want f=%0d ovf=%b cyc=%0d", k, f_o[k], ov[k], cyc, e.f, e.ovf, e.cyc + k + 3);
          else n_pass++;
        end
      end
      drive(stim.size() != 0 ? stim.pop_front() : mk(0, 0, 0, 0, 0, 0, 0));
    end
    for (int k = 0; k < NDUT; k++) begin
      n_total++;
      if (sb[k].size() != 0) $display("FAIL rst_mid_missing dut%0d got %0d pending want 0", k, sb[k].size());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
